// File: rtl/modsq_pkg.sv
// Shared types and constants for the modular-squaring result collector.
// Coefficient geometry of the wrapper's redundant output and the collector FSM states.
package modsq_pkg;

    localparam int WORD_LEN        = 16;
    localparam int BIT_LEN         = 17;
    localparam int SLOT_W          = 32;
    localparam int CARRY_W         = 2;
    localparam int MOD_LEN_DEFAULT = 1024;
    localparam int NUM_ELEMENTS    = MOD_LEN_DEFAULT / WORD_LEN + 1;

    typedef logic [BIT_LEN-1:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        NORM,
        PRESENT
    } state_t;

endpackage

// File: rtl/modsq_carry_normalizer.sv
// Captures the redundant coefficients and ripples their carries serially,
// one coefficient per cycle, into a plain binary result word.
module modsq_carry_normalizer
    import modsq_pkg::*;
#(
    parameter int N_COEF = NUM_ELEMENTS
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_load,
    input  logic [N_COEF*SLOT_W-1:0]   i_sq_out,
    output logic                       o_done,
    output logic [N_COEF*WORD_LEN-1:0] o_result,
    output logic                       o_overflow
);

    localparam int IDX_W = (N_COEF > 1) ? $clog2(N_COEF) : 1;
    localparam int HI_W  = SLOT_W - BIT_LEN;
    localparam int RES_W = N_COEF * WORD_LEN;

    coef_t [N_COEF-1:0]      w_coef;
    logic  [N_COEF*HI_W-1:0] w_unused_hi;
    logic  [BIT_LEN:0]       w_sum;
    logic  [CARRY_W-1:0]     w_carry_next;

    coef_t [N_COEF-1:0]      r_shadow;
    logic  [IDX_W-1:0]       r_idx;
    logic  [CARRY_W-1:0]     r_carry;
    logic                    r_active;
    logic                    r_done;
    logic  [RES_W-1:0]       r_result;
    logic                    r_overflow;

    // Only the low BIT_LEN bits of each 32-bit slot carry information.
    for (genvar k = 0; k < N_COEF; k++) begin : g_slot
        assign w_coef[k] = i_sq_out[k*SLOT_W +: BIT_LEN];
        assign w_unused_hi[k*HI_W +: HI_W] = i_sq_out[k*SLOT_W+BIT_LEN +: HI_W];
    end

    // The shadow shifts down each cycle, so element 0 is always the current index.
    assign w_sum        = {1'b0, r_shadow[0]} + {{(BIT_LEN+1-CARRY_W){1'b0}}, r_carry};
    assign w_carry_next = w_sum[BIT_LEN:WORD_LEN];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_shadow   <= '0;
            r_idx      <= '0;
            r_carry    <= '0;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_load) begin
                r_shadow <= w_coef;
                r_idx    <= '0;
                r_carry  <= '0;
                r_active <= 1'b1;
            end else if (r_active) begin
                r_shadow <= {coef_t'(0), r_shadow[N_COEF-1:1]};
                r_result <= {w_sum[WORD_LEN-1:0], r_result[RES_W-1:WORD_LEN]};
                r_carry  <= w_carry_next;
                if (r_idx == IDX_W'(N_COEF - 1)) begin
                    r_active   <= 1'b0;
                    r_done     <= 1'b1;
                    r_overflow <= (w_carry_next != '0);
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_result   = r_result;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/modsq_result_collector.sv
// Drives a modular-squaring job: start pulse, squaring count up to T, capture and
// normalization of the final coefficients, and valid/ready delivery to the host.
module modsq_result_collector
    import modsq_pkg::*;
#(
    parameter  int MOD_LEN     = 1024,
    parameter  int ITER_W      = 64,
    localparam int N_COEF      = MOD_LEN / WORD_LEN + 1,
    localparam int SQ_OUT_BITS = N_COEF * WORD_LEN * 2,
    localparam int RES_W       = N_COEF * WORD_LEN
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic [ITER_W-1:0]      cfg_iters,
    output logic                   sq_start,
    input  logic [SQ_OUT_BITS-1:0] sq_out,
    input  logic                   sq_valid,
    output logic                   busy,
    output logic [RES_W-1:0]       result,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic                   overflow
);

    state_t            r_state;
    logic [ITER_W-1:0] r_iters;
    logic [ITER_W-1:0] r_count;
    logic              r_sq_start;
    logic              r_busy;
    logic              r_result_valid;

    logic [ITER_W-1:0] w_count_inc;
    logic              w_capture;
    logic              w_norm_done;

    // Capture happens on the T-th squaring, before the counter could ever reach T.
    assign w_count_inc = r_count + ITER_W'(1);
    assign w_capture   = (r_state == RUN) && sq_valid && (w_count_inc == r_iters);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_iters        <= '0;
            r_count        <= '0;
            r_sq_start     <= 1'b0;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_sq_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (run) begin
                        r_iters    <= (cfg_iters == '0) ? ITER_W'(1) : cfg_iters;
                        r_count    <= '0;
                        r_sq_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (sq_valid) begin
                        r_count <= w_count_inc;
                        if (w_capture) begin
                            r_state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (w_norm_done) begin
                        r_result_valid <= 1'b1;
                        r_state        <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (result_ready) begin
                        r_result_valid <= 1'b0;
                        r_busy         <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    modsq_carry_normalizer #(
        .N_COEF (N_COEF)
    ) u_norm (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_capture),
        .i_sq_out   (sq_out),
        .o_done     (w_norm_done),
        .o_result   (result),
        .o_overflow (overflow)
    );

    assign sq_start     = r_sq_start;
    assign busy         = r_busy;
    assign result_valid = r_result_valid;

endmodule
